// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: latches a row of BCD/hex nibbles and scans
// one digit per slot, with blanking, lamp test and leading-zero suppression.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int COMMON_ANODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  BI_n,
    input  logic                  LT_n,
    input  logic                  LE,
    input  logic                  RBI_n,
    input  logic [4*DIGITS-1:0]   D,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic INV = (COMMON_ANODE != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] latch_q;
    logic [3:0]          nib;
    logic                blank;
    logic                zero_run;
    logic [DIGITS-1:0]   onehot;
    logic [6:0]          seg_ah;
    logic [DIGITS-1:0]   dig_ah;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down so zero_run tells whether every
    // nibble from the current position upward is zero.
    always_comb begin
        nib      = '0;
        blank    = 1'b0;
        zero_run = 1'b1;
        onehot   = '0;
        for (int unsigned k = DIGITS; k > 0; k--) begin
            zero_run = zero_run & (latch_q[4*(k-1) +: 4] == 4'h0);
            if (IW'(k - 1) == idx) begin
                nib           = latch_q[4*(k-1) +: 4];
                onehot[k-1]   = 1'b1;
                blank         = zero_run && (k > 1);
            end
        end
    end

    always_comb begin
        seg_ah = decode(nib);
        if (!BI_n)
            seg_ah = 7'h00;
        else if (!LT_n)
            seg_ah = 7'h7F;
        else if (!RBI_n && blank)
            seg_ah = 7'h00;
        dig_ah = (cnt == '0) ? '0 : onehot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            latch_q <= '0;
            seg     <= {7{INV}};
            dig     <= {DIGITS{INV}};
        end else begin
            if (!LE)
                latch_q <= D;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            seg <= seg_ah ^ {7{INV}};
            dig <= dig_ah ^ {DIGITS{INV}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, PRESCALE=4), with a second
// common-anode instance sharing the same inputs.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        bi_n, lt_n, le, rbi_n;
    logic [15:0] d;
    logic [6:0]  seg, seg_ca;
    logic [3:0]  dig, dig_ca;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .COMMON_ANODE(0)) dut (
        .clk(clk), .rst(rst), .BI_n(bi_n), .LT_n(lt_n), .LE(le), .RBI_n(rbi_n),
        .D(d), .seg(seg), .dig(dig)
    );

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .COMMON_ANODE(1)) dut_ca (
        .clk(clk), .rst(rst), .BI_n(bi_n), .LT_n(lt_n), .LE(le), .RBI_n(rbi_n),
        .D(d), .seg(seg_ca), .dig(dig_ca)
    );

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
        bit         chk_seg;
    } step_t;

    typedef struct {
        logic [15:0]      d;
        logic             le, bi, lt, rbi;
        logic [3:0][6:0]  exp;   // exp[k] = expected seg while digit k is enabled
    } vec_t;

    step_t seq[18];
    vec_t  vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s dig edge %0d", tag, i + 1), 32'(dig), 32'(seq[i].dig));
            if (seq[i].chk_seg)
                chk($sformatf("%s seg edge %0d", tag, i + 1), 32'(seg), 32'(seq[i].seg));
        end
    endtask

    task automatic run_vec(input int v);
        logic [6:0] cap [4];
        int         seen [4];
        int         dead;
        int         bad;
        bit         scan_ok;
        d = vecs[v].d; le = vecs[v].le; bi_n = vecs[v].bi; lt_n = vecs[v].lt; rbi_n = vecs[v].rbi;
        tick();
        tick();
        dead = 0;
        bad  = 0;
        for (int k = 0; k < 4; k++) begin
            seen[k] = 0;
            cap[k]  = 7'hxx;
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            if (dig == 4'b0000) dead++;
            else if (dig == 4'b0001) begin seen[0]++; cap[0] = seg; end
            else if (dig == 4'b0010) begin seen[1]++; cap[1] = seg; end
            else if (dig == 4'b0100) begin seen[2]++; cap[2] = seg; end
            else if (dig == 4'b1000) begin seen[3]++; cap[3] = seg; end
            else bad++;
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("vec%0d seg digit %0d", v, k), 32'(cap[k]), 32'(vecs[v].exp[k]));
        scan_ok = (dead == 4) && (bad == 0) && (seen[0] == 3) && (seen[1] == 3)
                  && (seen[2] == 3) && (seen[3] == 3);
        chk($sformatf("vec%0d scan dead=%0d bad=%0d slots=%0d/%0d/%0d/%0d", v, dead, bad,
                      seen[0], seen[1], seen[2], seen[3]), 32'(scan_ok), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dead_ca;
        int slot0_ca;

        // Scan sequence after reset release with D=4321h
        seq[0]  = '{4'b0000, 7'h00, 1'b0};
        seq[1]  = '{4'b0001, 7'h30, 1'b1};
        seq[2]  = '{4'b0001, 7'h30, 1'b1};
        seq[3]  = '{4'b0001, 7'h30, 1'b1};
        seq[4]  = '{4'b0000, 7'h00, 1'b0};
        seq[5]  = '{4'b0010, 7'h6D, 1'b1};
        seq[6]  = '{4'b0010, 7'h6D, 1'b1};
        seq[7]  = '{4'b0010, 7'h6D, 1'b1};
        seq[8]  = '{4'b0000, 7'h00, 1'b0};
        seq[9]  = '{4'b0100, 7'h79, 1'b1};
        seq[10] = '{4'b0100, 7'h79, 1'b1};
        seq[11] = '{4'b0100, 7'h79, 1'b1};
        seq[12] = '{4'b0000, 7'h00, 1'b0};
        seq[13] = '{4'b1000, 7'h33, 1'b1};
        seq[14] = '{4'b1000, 7'h33, 1'b1};
        seq[15] = '{4'b1000, 7'h33, 1'b1};
        seq[16] = '{4'b0000, 7'h00, 1'b0};
        seq[17] = '{4'b0001, 7'h30, 1'b1};

        //              D         LE    BI    LT    RBI    exp {d3, d2, d1, d0}
        vecs[0]  = '{16'h0070, 1'b0, 1'b1, 1'b1, 1'b0, {7'h00, 7'h00, 7'h70, 7'h7E}};
        vecs[1]  = '{16'h0070, 1'b0, 1'b1, 1'b1, 1'b1, {7'h7E, 7'h7E, 7'h70, 7'h7E}};
        vecs[2]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, {7'h00, 7'h00, 7'h00, 7'h7E}};
        vecs[3]  = '{16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, {7'h30, 7'h6D, 7'h79, 7'h33}};
        vecs[4]  = '{16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, {7'h30, 7'h6D, 7'h79, 7'h33}};
        vecs[5]  = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1, {7'h47, 7'h47, 7'h47, 7'h47}};
        vecs[6]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[7]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00}};
        vecs[8]  = '{16'h0305, 1'b0, 1'b1, 1'b1, 1'b0, {7'h00, 7'h79, 7'h7E, 7'h5B}};
        vecs[9]  = '{16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0, {7'h77, 7'h1F, 7'h4E, 7'h3D}};
        vecs[10] = '{16'h6789, 1'b0, 1'b1, 1'b1, 1'b1, {7'h5F, 7'h70, 7'h7F, 7'h7B}};
        vecs[11] = '{16'hE000, 1'b0, 1'b1, 1'b1, 1'b0, {7'h4F, 7'h7E, 7'h7E, 7'h7E}};

        rst = 1'b1; d = 16'h4321; le = 1'b0; bi_n = 1'b1; lt_n = 1'b1; rbi_n = 1'b1;
        #12;
        chk("reset seg", 32'(seg), 32'(7'h00));
        chk("reset dig", 32'(dig), 32'(4'b0000));
        chk("reset seg ca", 32'(seg_ca), 32'(7'h7F));
        chk("reset dig ca", 32'(dig_ca), 32'(4'b1111));

        @(posedge clk);
        #1 rst = 1'b0;
        run_seq(10, "scan1");

        // cnt=2 of digit 2: reset must act without waiting for a clock
        rst = 1'b1;
        #1;
        chk("midslot rst seg", 32'(seg), 32'(7'h00));
        chk("midslot rst dig", 32'(dig), 32'(4'b0000));
        chk("midslot rst seg ca", 32'(seg_ca), 32'(7'h7F));
        chk("midslot rst dig ca", 32'(dig_ca), 32'(4'b1111));
        @(posedge clk);
        #1 rst = 1'b0;
        run_seq(18, "scan2");

        for (int v = 0; v < 12; v++)
            run_vec(v);

        // Common-anode instance with D=0008h
        d = 16'h0008; le = 1'b0; bi_n = 1'b1; lt_n = 1'b1; rbi_n = 1'b1;
        tick();
        tick();
        dead_ca  = 0;
        slot0_ca = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (dig_ca == 4'b1111) dead_ca++;
            else if (dig_ca == 4'b1110) begin
                slot0_ca++;
                chk($sformatf("ca digit0 seg c%0d", c), 32'(seg_ca), 32'(7'h00));
            end else if (dig_ca == 4'b1101) begin
                chk($sformatf("ca digit1 seg c%0d", c), 32'(seg_ca), 32'(7'h01));
            end
        end
        chk("ca dead slots", 32'(dead_ca), 32'(4));
        chk("ca digit0 slots", 32'(slot0_ca), 32'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
